median3_frame_filter: RTL and testbench
=======================================

Name: median3_frame_filter

Overview:
- Frame-buffered, pipelined 3-tap horizontal median filter for a 64-row x 20-column image of 8-bit pixels.
- Host loads the source frame through a write port and pulses start.
- The block streams every pixel through a compare-swap median pipeline into a result frame buffer.
- Host reads the filtered frame back through a registered read port. The block sits between pixel capture and downstream image consumers.

Parameters:
- ROWS, 64, image rows
- COLS, 20, image columns (pixels per row)
- DW, 8, pixel width in bits
- ADDR_W, 11, address width; must satisfy 2**ADDR_W >= ROWS*COLS

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one source pixel this cycle
- wr_addr  in  ADDR_W  source pixel address, row-major: r*COLS+c
- wr_data  in  DW  source pixel value
- start  in  1  one-cycle pulse: filter the current source frame
- busy  out  1  high while filtering
- done  out  1  one-cycle pulse when the result frame is complete
- rd_addr  in  ADDR_W  result pixel address, row-major
- rd_data  out  DW  result pixel, registered

Behaviour:
- Reset (async, rst_n=0): busy=0, done=0, rd_data=0, FSM=IDLE, pipeline valid bits cleared. Memory contents are not reset.
- FSM states:
  - IDLE: waits for start.
  - RUN: start accepted; read pointer sweeps 0..ROWS*COLS-1, one pixel per cycle.
  - DRAIN: pipeline flush.
  - DONE: one cycle, done=1, then IDLE.
- busy=1 in RUN and DRAIN, and rises the cycle after start is sampled.
- Total time: done is high exactly ROWS*COLS+PIPE_LAT+1 cycles after the start edge. PIPE_LAT=4 is a fixed localparam (memory read, window shift, two sort stages). The implementation pads to this count.
- Result: res[r][c] = median(src[r][cl], src[r][c], src[r][cr]), with cl=max(c-1,0) and cr=min(c+1,COLS-1).
  - The window never crosses row boundaries; edge pixels replicate.
  - Consequence: res[r][0] = median(src[r][0], src[r][0], src[r][1]) = src[r][0].
- Median arithmetic: unsigned compares only. Ties are resolved by value, so output is deterministic.
- Writes:
  - wr_en while busy=0: src[wr_addr]<=wr_data.
  - wr_en while busy=1: ignored, so the source frame is stable during filtering.
  - wr_addr >= ROWS*COLS: write ignored.
- start while busy=1 or in DONE: ignored.
- Reads: rd_data <= res[rd_addr] one cycle after rd_addr. Reads are allowed any time. During busy, rd_data returns the partially updated result buffer. rd_addr >= ROWS*COLS returns 0.
- Reset mid-operation: FSM returns to IDLE and busy and done clear immediately. The result buffer holds a partial frame. The source buffer is retained.
- Re-running start without reloading produces an identical result frame.

Optional Feature:
- PERF_CNT_EN defined: adds output port frame_cnt[15:0].
  - Reset to 0; increments on each done pulse; wraps 0xFFFF->0.
- PERF_CNT_EN undefined: port and counter absent. All other behaviour is identical.

Decomposition:
- Package median_pkg: ROWS, COLS, DW, ADDR_W, PIPE_LAT; typedef pixel_t (logic [DW-1:0]); typedef enum state_t {IDLE, RUN, DRAIN, DONE}.
- One sub-module median3_sort: 3-input, 2-stage registered compare-swap network with valid in/out, outputting the middle value.
- Top holds both frame buffers, the FSM, address/column counters and edge replication.

Test Plan:
- Ramp rows: src[r][c]=c for all r; start -> after done, res[r][c]=c everywhere. done appears exactly 1285 cycles after start; busy is high 1284 cycles.
- Impulse: row 5 all 0x10 except src[5][7]=0xFF -> res[5][7]=0x10, and all other row-5 pixels are 0x10.
- Edges: src[2][0]=0x30, src[2][1]=0x05, src[2][18]=0x90, src[2][19]=0x01 -> res[2][0]=0x30 and res[2][19]=0x01. Row 3 pixels are unaffected by row 2.
- Descending triple: src[0][3..5]=0xC0,0x80,0x40 -> res[0][4]=0x80.
- Protocol: second start and wr_en(addr 0, 0xAA) issued during busy -> both ignored. Exactly one done; src[0] unchanged.
- Reset mid-run: rst_n low at cycle 300 of RUN -> busy=0, done=0, rd_data=0 immediately. A new start then yields a full correct frame.

Source files
------------

// File: rtl/median_pkg.sv
// Shared constants, pixel type and controller states for the 3-tap median frame filter.
package median_pkg;

    localparam int ROWS     = 64;
    localparam int COLS     = 20;
    localparam int DW       = 8;
    localparam int ADDR_W   = 11;
    localparam int PIPE_LAT = 4;
    localparam int NPIX     = ROWS * COLS;
    localparam int COL_W    = $clog2(COLS);

    typedef logic [DW-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic last_col(input logic [COL_W-1:0] c);
        return c == COL_W'(COLS - 1);
    endfunction

endpackage

// File: rtl/median3_sort.sv
// Two-stage registered compare-swap network returning the middle of three unsigned pixels.
module median3_sort
    import median_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   vld_in,
    input  pixel_t a,
    input  pixel_t b,
    input  pixel_t c,
    output logic   vld_out,
    output pixel_t med
);

    function automatic pixel_t umin(input pixel_t x, input pixel_t y);
        return (x < y) ? x : y;
    endfunction

    function automatic pixel_t umax(input pixel_t x, input pixel_t y);
        return (x < y) ? y : x;
    endfunction

    pixel_t lo_p0, hi_p0, c_p0;
    pixel_t med_p1;
    logic   vld_p0, vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= vld_in;
            vld_p1 <= vld_p0;
        end
    end

    // p0: order a/b; p1: clamp c into [lo, hi], which is the median
    always_ff @(posedge clk) begin
        lo_p0  <= umin(a, b);
        hi_p0  <= umax(a, b);
        c_p0   <= c;
        med_p1 <= umax(lo_p0, umin(hi_p0, c_p0));
    end

    assign vld_out = vld_p1;
    assign med     = med_p1;

endmodule

// File: rtl/median3_frame_filter.sv
// Frame-buffered 3-tap horizontal median filter with edge replication.
// Optional PERF_CNT_EN adds a 16-bit count of completed frames.
module median3_frame_filter
    import median_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DW-1:0]     rd_data
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    pixel_t src_mem [NPIX];
    pixel_t res_mem [NPIX];

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [COL_W-1:0]  col;
    logic [2:0]        dcnt;

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // DRAIN is padded to PIPE_LAT cycles so the frame time is fixed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            col   <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        ptr   <= '0;
                        col   <= '0;
                    end
                end
                RUN: begin
                    if (ptr == ADDR_W'(NPIX - 1)) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                        col <= last_col(col) ? '0 : col + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt == 3'(PIPE_LAT - 1))
                        state <= DONE;
                    else
                        dcnt <= dcnt + 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !busy && (wr_addr < ADDR_W'(NPIX)))
            src_mem[wr_addr] <= wr_data;
    end

    pixel_t            pix_p0, cen_p1, lft_p1;
    logic [COL_W-1:0]  col_p0, col_p1;
    logic [ADDR_W-1:0] addr_p0, addr_p1, addr_p2, addr_p3;
    logic              vld_p0, vld_p1;
    pixel_t            win_l, win_r;
    pixel_t            med_p3;
    logic              vld_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= (state == RUN);
            vld_p1 <= vld_p0;
        end
    end

    // p0: source read; p1: centre/left history, right neighbour is the live p0 pixel
    always_ff @(posedge clk) begin
        pix_p0  <= src_mem[ptr];
        col_p0  <= col;
        addr_p0 <= ptr;
        cen_p1  <= pix_p0;
        lft_p1  <= cen_p1;
        col_p1  <= col_p0;
        addr_p1 <= addr_p0;
        addr_p2 <= addr_p1;
        addr_p3 <= addr_p2;
    end

    always_comb begin
        win_l = (col_p1 == '0)    ? cen_p1 : lft_p1;
        win_r = last_col(col_p1)  ? cen_p1 : pix_p0;
    end

    median3_sort u_sort (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (vld_p1),
        .a       (win_l),
        .b       (cen_p1),
        .c       (win_r),
        .vld_out (vld_p3),
        .med     (med_p3)
    );

    always_ff @(posedge clk) begin
        if (vld_p3)
            res_mem[addr_p3] <= med_p3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= (rd_addr < ADDR_W'(NPIX)) ? res_mem[rd_addr] : '0;
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (state == DONE)
            frame_cnt <= frame_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_median3_frame_filter.sv
// Scoreboard bench for median3_frame_filter: frame loads, runs, timing and full read-back.
module tb_median3_frame_filter;
    import median_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              start = 1'b0;
    logic              busy, done;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DW-1:0]     rd_data;
`ifdef PERF_CNT_EN
    logic [15:0]       frame_cnt;
    int                nframes = 0;
`endif

    median3_frame_filter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
`ifdef PERF_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         nchk = 0;
    int         nerr = 0;
    logic [7:0] src_m [NPIX];
    logic [7:0] exp_q [$];
    string      tag_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
        if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
        return c;
    endfunction

    function automatic logic [7:0] model_res(input int addr);
        int r, c, cl, cr;
        r  = addr / COLS;
        c  = addr % COLS;
        cl = (c == 0) ? 0 : c - 1;
        cr = (c == COLS - 1) ? c : c + 1;
        return med3(src_m[r*COLS+cl], src_m[addr], src_m[r*COLS+cr]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int addr, input logic [7:0] v);
        wr_en   = 1'b1;
        wr_addr = addr[ADDR_W-1:0];
        wr_data = v;
        tick();
        wr_en = 1'b0;
        if (addr < NPIX) src_m[addr] = v;
    endtask

    task automatic read_push(input int addr, input string tag, input logic [7:0] exp);
        rd_addr = addr[ADDR_W-1:0];
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        check(tag_q.pop_front(), 32'(rd_data), 32'(exp_q.pop_front()));
    endtask

    task automatic verify_frame(input string tag);
        for (int a = 0; a < NPIX; a++)
            read_push(a, $sformatf("%s_res[%0d]", tag, a), model_res(a));
        read_push(NPIX, {tag, "_oob_lo"}, 8'h00);
        read_push(2047, {tag, "_oob_hi"}, 8'h00);
    endtask

    // cycle 1 is the first cycle after the edge that samples start
    task automatic run_frame(input string tag, input bit disturb);
        int cyc, bcnt, extra;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc  = 1;
        bcnt = busy ? 1 : 0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        while (!done && cyc < 3000) begin
            start   = disturb && (cyc == 100);
            wr_en   = start;
            wr_addr = '0;
            wr_data = 8'hAA;
            tick();
            cyc++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, "_done_lat"}, 32'(cyc), 32'd1285);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd1284);
`ifdef PERF_CNT_EN
        nframes++;
`endif
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        extra = 0;
        repeat (20) begin
            tick();
            if (done) extra++;
        end
        check({tag, "_extra_done"}, 32'(extra), 32'd0);
`ifdef PERF_CNT_EN
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(nframes));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < NPIX; a++) write_px(a, 8'(a % COLS));
        run_frame("ramp", 1'b0);
        verify_frame("ramp");
        read_push(9*COLS + 13, "ramp_9_13", 8'd13);

        for (int c = 0; c < COLS; c++) write_px(5*COLS + c, (c == 7) ? 8'hFF : 8'h10);
        write_px(2*COLS + 0,  8'h30);
        write_px(2*COLS + 1,  8'h05);
        write_px(2*COLS + 18, 8'h90);
        write_px(2*COLS + 19, 8'h01);
        write_px(3, 8'hC0);
        write_px(4, 8'h80);
        write_px(5, 8'h40);
        for (int a = 8*COLS; a < NPIX; a++) write_px(a, 8'($urandom_range(0, 255)));
        write_px(NPIX + 3, 8'h77);
        run_frame("pat", 1'b0);
        verify_frame("pat");
        read_push(5*COLS + 7,  "impulse_5_7", 8'h10);
        read_push(5*COLS + 0,  "impulse_5_0", 8'h10);
        read_push(2*COLS + 0,  "edge_2_0",    8'h30);
        read_push(2*COLS + 19, "edge_2_19",   8'h01);
        read_push(3*COLS + 0,  "row3_0",      8'h00);
        read_push(4,           "desc_0_4",    8'h80);

        run_frame("proto", 1'b1);
        verify_frame("proto");
        read_push(0, "src0_kept", 8'h00);

        rd_addr = ADDR_W'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (300) tick();
        check("pre_rst_rd_data", 32'(rd_data), 32'(model_res(4)));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
`ifdef PERF_CNT_EN
        nframes = 0;
`endif
        run_frame("after_rst", 1'b0);
        verify_frame("after_rst");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
